// File: rtl/mot_ser_tx.sv
// Dual-lane framed serializer for the motor serial I/O link.
// One TX_WE launches a SYNC / SHIFT / GAP frame driving SER_CLK, SER_SYNC and two data lanes.
module mot_ser_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic [31:0] TX_DI,
  input  logic        TX_WE,
  input  logic        ABORT,
  input  logic        OVR_CLR,
  output logic        TX_BUSY,
  output logic        TX_DONE,
  output logic        OVERRUN,
  output logic        SER_CLK,
  output logic        SER_SYNC,
  output logic        SER_DATA0,
  output logic        SER_DATA1
);

  // state | meaning
  // IDLE  | waiting for TX_WE
  // SYNC  | SER_SYNC high for two half-periods, lane MSBs presented
  // SHIFT | one bit per SER_CLK period, low phase then high phase
  // GAP   | two quiet half-periods; TX_DONE on the final cycle
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;

  localparam logic [7:0]  DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [4:0]  BIT_TOP    = 5'(FRAME_BITS - 1);
  localparam logic [15:0] LANE_MASK  = 16'((33'h1 << FRAME_BITS) - 33'h1);

  state_t      state_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_q;
  logic        phase_q;
  logic [15:0] sh0_q, sh1_q;
  logic [15:0] sh0_d, sh1_d;
  logic        busy_q, done_q, ovr_q;
  logic        sclk_q, sync_q, d0_q, d1_q;

  always_comb begin
    sh0_d = sh0_q << 1;
    sh1_d = sh1_q << 1;
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      phase_q <= 1'b0;
      sh0_q   <= 16'd0;
      sh1_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sync_q  <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
    end else if (ABORT) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      phase_q <= 1'b0;
      sh0_q   <= 16'd0;
      sh1_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sync_q  <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (TX_WE) begin
            state_q <= SYNC;
            div_q   <= DIV_RELOAD;
            phase_q <= 1'b0;
            bit_q   <= BIT_TOP;
            sh0_q   <= TX_DI[15:0] & LANE_MASK;
            sh1_q   <= TX_DI[31:16] & LANE_MASK;
            busy_q  <= 1'b1;
            sync_q  <= 1'b1;
            d0_q    <= TX_DI[FRAME_BITS-1];
            d1_q    <= TX_DI[16+FRAME_BITS-1];
          end
        end
        SYNC: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else begin
            div_q <= DIV_RELOAD;
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              state_q <= SHIFT;
              sync_q  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else begin
            div_q <= DIV_RELOAD;
            if (!phase_q) begin
              phase_q <= 1'b1;
              sclk_q  <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              sclk_q  <= 1'b0;
              if (bit_q == 5'd0) begin
                state_q <= GAP;
                d0_q    <= 1'b0;
                d1_q    <= 1'b0;
              end else begin
                // next bit changes only as the low phase opens
                bit_q <= bit_q - 5'd1;
                sh0_q <= sh0_d;
                sh1_q <= sh1_d;
                d0_q  <= sh0_d[FRAME_BITS-1];
                d1_q  <= sh1_d[FRAME_BITS-1];
              end
            end
          end
        end
        GAP: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
            // DONE lands on the last gap cycle so the frame is 2*CLK_DIV*(FRAME_BITS+2) long
            if (phase_q && div_q == 8'd1) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end else if (!phase_q) begin
            phase_q <= 1'b1;
            div_q   <= DIV_RELOAD;
          end else begin
            phase_q <= 1'b0;
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      ovr_q <= 1'b0;
    end else if (TX_WE && state_q != IDLE) begin
      ovr_q <= 1'b1;
    end else if (OVR_CLR) begin
      ovr_q <= 1'b0;
    end
  end

  assign TX_BUSY   = busy_q;
  assign TX_DONE   = done_q;
  assign OVERRUN   = ovr_q;
  assign SER_CLK   = sclk_q;
  assign SER_SYNC  = sync_q;
  assign SER_DATA0 = d0_q;
  assign SER_DATA1 = d1_q;

endmodule

// File: tb/tb_mot_ser_tx.sv
// Bench for mot_ser_tx: a fast instance (CLK_DIV=2) and a default instance share stimulus,
// each checked every cycle against a frame-position model plus literal frame expectations.
module tb_mot_ser_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] di = 32'd0;
  logic        we = 1'b0, abort = 1'b0, ovrclr = 1'b0;
  logic [1:0]  busy, done, ovr, sclk, ssync, sd0, sd1;

  always #5 clk = ~clk;

  mot_ser_tx #(.CLK_DIV(2), .FRAME_BITS(16)) u_fast (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .TX_DI(di), .TX_WE(we), .ABORT(abort), .OVR_CLR(ovrclr),
    .TX_BUSY(busy[0]), .TX_DONE(done[0]), .OVERRUN(ovr[0]), .SER_CLK(sclk[0]),
    .SER_SYNC(ssync[0]), .SER_DATA0(sd0[0]), .SER_DATA1(sd1[0]));

  mot_ser_tx u_dflt (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .TX_DI(di), .TX_WE(we), .ABORT(abort), .OVR_CLR(ovrclr),
    .TX_BUSY(busy[1]), .TX_DONE(done[1]), .OVERRUN(ovr[1]), .SER_CLK(sclk[1]),
    .SER_SYNC(ssync[1]), .SER_DATA0(sd0[1]), .SER_DATA1(sd1[1]));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model: frame position per instance
  int          DV[2]  = '{2, 16};
  int          FBV[2] = '{16, 16};
  bit          m_act[2];
  int          m_k[2];
  logic [15:0] m_l0[2], m_l1[2];
  bit          m_ovr[2];

  function automatic int flen(input int i);
    return 2 * DV[i] * (FBV[i] + 2);
  endfunction

  function automatic logic [15:0] fmask(input int i);
    logic [16:0] one;
    one = 17'h1;
    return 16'((one << FBV[i]) - 17'h1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0;
        m_k[i]   = 0;
        m_ovr[i] = 1'b0;
      end else begin
        if (we && m_act[i]) m_ovr[i] = 1'b1;
        else if (ovrclr) m_ovr[i] = 1'b0;
        if (abort) m_act[i] = 1'b0;
        else if (m_act[i]) begin
          if (m_k[i] == flen(i) - 1) m_act[i] = 1'b0;
          else m_k[i] = m_k[i] + 1;
        end else if (we) begin
          m_act[i] = 1'b1;
          m_k[i]   = 0;
          m_l0[i]  = di[15:0] & fmask(i);
          m_l1[i]  = di[31:16] & fmask(i);
        end
      end
    end
  end

  // {busy, done, overrun, ser_clk, ser_sync, data0, data1}
  function automatic logic [6:0] exp_out(input int i);
    int d, fb, k, m, j;
    logic [15:0] l0, l1;
    d = DV[i]; fb = FBV[i]; k = m_k[i]; l0 = m_l0[i]; l1 = m_l1[i];
    if (!m_act[i]) return {2'b00, m_ovr[i], 4'b0000};
    if (k < 2 * d) return {1'b1, 1'b0, m_ovr[i], 1'b0, 1'b1, l0[fb-1], l1[fb-1]};
    if (k < 2 * d * (fb + 1)) begin
      m = k - 2 * d;
      j = fb - 1 - m / (2 * d);
      return {1'b1, 1'b0, m_ovr[i], ((m % (2 * d)) >= d), 1'b0, l0[j], l1[j]};
    end
    return {(k != flen(i) - 1), (k == flen(i) - 1), m_ovr[i], 4'b0000};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      check($sformatf("cycle_inst%0d", i),
            {25'd0, busy[i], done[i], ovr[i], sclk[i], ssync[i], sd0[i], sd1[i]},
            {25'd0, exp_out(i)});
  end

  int          r_len, r_sync, r_rises, r_hmin, r_hmax;
  logic [15:0] r_b0, r_b1;
  logic        r_busy_done;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_we(input logic [31:0] data);
    @(negedge clk);
    di = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  // starts a frame and measures instance inst from its first SYNC cycle to DONE
  task automatic run_frame(input logic [31:0] data, input int inst);
    logic prev;
    int hr;
    r_len = 0; r_sync = 0; r_rises = 0; r_hmin = 1000000; r_hmax = 0;
    r_b0 = 16'd0; r_b1 = 16'd0; r_busy_done = 1'b1; prev = 1'b0; hr = 0;
    pulse_we(data);
    for (int c = 0; c < 800; c++) begin
      if (ssync[inst]) r_sync++;
      if (sclk[inst]) begin
        if (!prev) begin
          r_rises++;
          r_b0 = {r_b0[14:0], sd0[inst]};
          r_b1 = {r_b1[14:0], sd1[inst]};
        end
        hr++;
      end else if (prev) begin
        if (hr < r_hmin) r_hmin = hr;
        if (hr > r_hmax) r_hmax = hr;
        hr = 0;
      end
      prev = sclk[inst];
      if (done[inst]) begin
        r_len = c + 1;
        r_busy_done = busy[inst];
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int sw;
    bit seen;
    wait_cycles(3);
    check("reset_outputs", {18'd0, busy, done, ovr, sclk, ssync, sd0, sd1}, 32'd0);
    #2 rst_n = 1'b1;

    run_frame(32'hA5A5_3C3C, 0);
    check("f1_len", r_len, 72);
    check("f1_sync_w", r_sync, 4);
    check("f1_rises", r_rises, 16);
    check("f1_data0", r_b0, 16'b0011110000111100);
    check("f1_data1", r_b1, 16'b1010010110100101);
    check("f1_busy_on_done", r_busy_done, 1'b0);
    wait_cycles(600);

    run_frame(32'hFFFF_0000, 1);
    check("f2_len", r_len, 576);
    check("f2_sync_w", r_sync, 32);
    check("f2_rises", r_rises, 16);
    check("f2_data0", r_b0, 16'h0000);
    check("f2_data1", r_b1, 16'hFFFF);
    check("f2_hi_min", r_hmin, 16);
    check("f2_hi_max", r_hmax, 16);
    wait_cycles(20);

    pulse_we(32'h1234_5678);
    wait_cycles(20);
    pulse_we(32'hFFFF_FFFF);
    wait_cycles(5);
    check("ovr_set", ovr, 2'b11);
    wait_cycles(600);
    check("ovr_sticky", ovr, 2'b11);
    @(negedge clk); ovrclr = 1'b1;
    @(negedge clk); ovrclr = 1'b0;
    check("ovr_clr", ovr, 2'b00);

    pulse_we(32'h0F0F_F0F0);
    wait_cycles(37);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_outs", {busy[0], done[0], sclk[0], ssync[0], sd0[0], sd1[0]}, 6'd0);
    check("abort_busy_dflt", busy[1], 1'b0);
    wait_cycles(100);
    run_frame(32'hA5A5_3C3C, 0);
    check("abort_restart_len", r_len, 72);
    check("abort_restart_d0", r_b0, 16'h3C3C);
    wait_cycles(600);

    pulse_we(32'h5555_AAAA);
    @(negedge clk);
    check("pre_rst_sync", ssync, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outs", {18'd0, busy, done, ovr, sclk, ssync, sd0, sd1}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    run_frame(32'hA5A5_3C3C, 0);
    check("post_rst_len", r_len, 72);
    check("post_rst_d1", r_b1, 16'hA5A5);
    wait_cycles(600);

    pulse_we(32'h1234_ABCD);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done[0]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("b2b_done_seen", seen, 1'b1);
    di = 32'hDEAD_BEEF; we = 1'b1;
    @(negedge clk);
    check("b2b_no_start", {busy[0], ssync[0], ovr[0]}, 3'b001);
    di = 32'hCAFE_F00D;
    @(negedge clk); we = 1'b0;
    sw = 0;
    for (int c = 0; c < 20 && ssync[0]; c++) begin
      sw++;
      @(negedge clk);
    end
    check("b2b_sync_w", sw, 4);
    wait_cycles(600);

    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      we     = ($urandom_range(0, 99) < 3);
      di     = $urandom;
      abort  = ($urandom_range(0, 999) < 2);
      ovrclr = ($urandom_range(0, 99) < 4);
    end
    @(negedge clk);
    we = 1'b0; abort = 1'b0; ovrclr = 1'b0;
    wait_cycles(600);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
